// File: rtl/game_selector.sv
// game_selector: mode/menu controller that picks one of NUM_GAMES cores, shows its index, then runs it.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   mode_pulse_i    advance to the next game and restart the menu
//   action_pulse_i  skip the menu in SHOW, forwarded to the running game in RUN
//   game_digit_i    4-bit digit per game, game g on [4g+3:4g]
//   game_dp_i       decimal point per game
//   game_sel_o      selected game index
//   game_en_o       one-hot run enable (RUN only)
//   game_clr_o      one-cycle one-hot clear on entering the game
//   game_action_o   one-cycle one-hot routed action pulse
//   disp_digit_o    digit to the seven-segment driver
//   disp_dp_o       decimal point to the seven-segment driver
//   in_menu_o       high in SHOW and CLEAR
module game_selector #(
   parameter int NUM_GAMES   = 4,
   parameter int MENU_CYCLES = 12_000_000,
   localparam int SW         = $clog2(NUM_GAMES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mode_pulse_i,
   input  logic                   action_pulse_i,
   input  logic [4*NUM_GAMES-1:0] game_digit_i,
   input  logic [NUM_GAMES-1:0]   game_dp_i,
   output logic [SW-1:0]          game_sel_o,
   output logic [NUM_GAMES-1:0]   game_en_o,
   output logic [NUM_GAMES-1:0]   game_clr_o,
   output logic [NUM_GAMES-1:0]   game_action_o,
   output logic [3:0]             disp_digit_o,
   output logic                   disp_dp_o,
   output logic                   in_menu_o
);
   localparam int TW = $clog2(MENU_CYCLES + 1);
   typedef enum logic [1:0] {SHOW, CLEAR, RUN} state_t;
   state_t                 state_q, state_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [SW-1:0]          game_sel_q, game_sel_d, sel_next;
   logic [NUM_GAMES-1:0]   game_en_q, game_en_d;
   logic [NUM_GAMES-1:0]   game_clr_q, game_clr_d;
   logic [NUM_GAMES-1:0]   game_action_q, game_action_d;
   logic [NUM_GAMES-1:0]   onehot;
   logic [3:0]             disp_digit_q, disp_digit_d;
   logic                   disp_dp_q, disp_dp_d;
   logic                   in_menu_q, in_menu_d;
   // Outputs are computed for the state being entered so they are registered
   // yet line up with that state; game_sel only changes on a jump back to SHOW.
   always_comb begin
      onehot        = NUM_GAMES'(1) << game_sel_q;
      sel_next      = (game_sel_q == SW'(NUM_GAMES - 1)) ? '0 : game_sel_q + 1'b1;
      state_d       = mode_pulse_i ? SHOW :
                      state_q == SHOW ? ((action_pulse_i || timer_q == TW'(MENU_CYCLES - 1)) ? CLEAR : SHOW) :
                      RUN;
      game_sel_d    = mode_pulse_i ? sel_next : game_sel_q;
      timer_d       = (state_q == SHOW && state_d == SHOW && !mode_pulse_i) ? timer_q + 1'b1 : '0;
      game_en_d     = (state_d == RUN) ? onehot : '0;
      game_clr_d    = (state_d == CLEAR) ? onehot : '0;
      game_action_d = (state_q == RUN && action_pulse_i && !mode_pulse_i) ? onehot : '0;
      disp_digit_d  = (state_d == RUN) ? game_digit_i[{game_sel_q, 2'b00} +: 4] : 4'(game_sel_d);
      disp_dp_d     = (state_d == RUN) ? game_dp_i[game_sel_q] : 1'b1;
      in_menu_d     = (state_d != RUN);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= SHOW;
         timer_q       <= '0;
         game_sel_q    <= '0;
         game_en_q     <= '0;
         game_clr_q    <= '0;
         game_action_q <= '0;
         disp_digit_q  <= '0;
         disp_dp_q     <= 1'b1;
         in_menu_q     <= 1'b1;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         game_sel_q    <= game_sel_d;
         game_en_q     <= game_en_d;
         game_clr_q    <= game_clr_d;
         game_action_q <= game_action_d;
         disp_digit_q  <= disp_digit_d;
         disp_dp_q     <= disp_dp_d;
         in_menu_q     <= in_menu_d;
      end
   end
   assign game_sel_o    = game_sel_q;
   assign game_en_o     = game_en_q;
   assign game_clr_o    = game_clr_q;
   assign game_action_o = game_action_q;
   assign disp_digit_o  = disp_digit_q;
   assign disp_dp_o     = disp_dp_q;
   assign in_menu_o     = in_menu_q;
endmodule
